// File: rtl/backtrack_stack.sv
// rtl/backtrack_stack.sv - LIFO store of per-level search state for the backtracking datapath
// Optional build macro BACKTRACK_STACK_HWM_EN adds the high_water occupancy port.
module backtrack_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top_data,
  output logic             top_valid,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
`ifdef BACKTRACK_STACK_HWM_EN
  ,
  output logic [CNT_W-1:0] high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] top_nxt;
  logic             ov_nxt, un_nxt, wr_en;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign top_valid = (state != S_EMPTY);

  // Entry just below the current top, used when a pop exposes it.
  assign rd_idx = AW'(count - TWO);

  always_comb begin
    count_nxt = count;
    top_nxt   = top_data;
    ov_nxt    = overflow;
    un_nxt    = underflow;
    wr_en     = 1'b0;
    wr_idx    = AW'(count);
    if (clear) begin
      count_nxt = '0;
      top_nxt   = '0;
      ov_nxt    = 1'b0;
      un_nxt    = 1'b0;
    end else if (push && pop && !empty) begin
      wr_en   = 1'b1;
      wr_idx  = AW'(count - ONE);
      top_nxt = push_data;
    end else if (push) begin
      // Also covers push+pop on an empty stack, which behaves as a plain push.
      if (full) begin
        ov_nxt = 1'b1;
      end else begin
        wr_en     = 1'b1;
        count_nxt = count + ONE;
        top_nxt   = push_data;
      end
    end else if (pop) begin
      if (empty) begin
        un_nxt = 1'b1;
      end else if (count == ONE) begin
        count_nxt = '0;
        top_nxt   = '0;
      end else begin
        count_nxt = count - ONE;
        top_nxt   = mem[rd_idx];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (push) state_nxt = S_PART;
        S_PART: begin
          if (push && !pop && count == DEPTH_C - ONE) state_nxt = S_FULL;
          else if (pop && !push && count == ONE)      state_nxt = S_EMPTY;
        end
        S_FULL:  if (pop && !push) state_nxt = S_PART;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      count     <= '0;
      top_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      top_data  <= top_nxt;
      overflow  <= ov_nxt;
      underflow <= un_nxt;
    end
  end

  // Storage needs no reset; gating with rst drops a write racing a reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= push_data;
  end

`ifdef BACKTRACK_STACK_HWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         high_water <= '0;
    else if (clear)                  high_water <= '0;
    else if (count_nxt > high_water) high_water <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_backtrack_stack.sv
// tb/tb_backtrack_stack.sv - directed and randomized check of backtrack_stack against a queue model
module tb_backtrack_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic [WIDTH-1:0] top_data;
  logic             top_valid, empty, full, overflow, underflow;
  logic [CNT_W-1:0] count;
`ifdef BACKTRACK_STACK_HWM_EN
  logic [CNT_W-1:0] high_water;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ov, m_un;
  int               m_hwm;

  backtrack_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .push_data(push_data),
    .pop(pop), .top_data(top_data), .top_valid(top_valid), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .underflow(underflow)
`ifdef BACKTRACK_STACK_HWM_EN
    , .high_water(high_water)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    m_hwm = 0;
  endtask

  task automatic model_step();
    if (clear) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_hwm = 0;
    end else if (push && pop && q.size() != 0) begin
      q[q.size()-1] = push_data;
    end else if (push) begin
      if (q.size() == DEPTH) m_ov = 1'b1;
      else q.push_back(push_data);
    end else if (pop) begin
      if (q.size() == 0) m_un = 1'b1;
      else void'(q.pop_back());
    end
    if (q.size() > m_hwm) m_hwm = q.size();
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_top;
    exp_top = (q.size() != 0) ? q[q.size()-1] : '0;
    check({tag, ".count"},     32'(count),     32'(q.size()));
    check({tag, ".top_data"},  32'(top_data),  32'(exp_top));
    check({tag, ".top_valid"}, 32'(top_valid), 32'(q.size() != 0));
    check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ov));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_un));
`ifdef BACKTRACK_STACK_HWM_EN
    check({tag, ".high_water"}, 32'(high_water), 32'(m_hwm));
`endif
  endtask

  task automatic cyc(input string tag, input logic c, input logic pu, input logic po,
                     input logic [WIDTH-1:0] d);
    clear = c; push = pu; pop = po; push_data = d;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
    clear = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset");
    cyc("idle", 0, 0, 0, 16'h0);

    cyc("lifo_push", 0, 1, 0, 16'h0011);
    cyc("lifo_push", 0, 1, 0, 16'h0022);
    cyc("lifo_push", 0, 1, 0, 16'h0033);
    check("lifo_cnt3", 32'(count), 32'd3);
    check("lifo_top33", 32'(top_data), 32'h0033);
    cyc("lifo_pop", 0, 0, 1, 16'h0);
    check("lifo_top22", 32'(top_data), 32'h0022);
    cyc("lifo_pop", 0, 0, 1, 16'h0);
    check("lifo_top11", 32'(top_data), 32'h0011);
    cyc("lifo_pop", 0, 0, 1, 16'h0);
    check("lifo_empty", 32'({top_valid, empty}), 32'b01);

    for (int i = 0; i < DEPTH; i++) cyc("fill", 0, 1, 0, 16'(16'h0100 + i));
    check("fill_full", 32'(full), 32'd1);
    cyc("ovf_push", 0, 1, 0, 16'hFFFF);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(count), 32'd16);
    check("ovf_top", 32'(top_data), 32'h010F);
    cyc("full_repl", 0, 1, 1, 16'h0BEE);

    cyc("clr", 1, 0, 0, 16'h0);
    cyc("unf_pop", 0, 0, 1, 16'h0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_cnt", 32'(count), 32'd0);
    cyc("unf_push", 0, 1, 0, 16'h0042);
    check("unf_top", 32'(top_data), 32'h0042);
    check("unf_sticky", 32'(underflow), 32'd1);

    cyc("clr", 1, 0, 0, 16'h0);
    cyc("sim_push", 0, 1, 0, 16'h0001);
    cyc("sim_push", 0, 1, 0, 16'h0002);
    cyc("sim_both", 0, 1, 1, 16'h00AA);
    check("sim_cnt", 32'(count), 32'd2);
    check("sim_top", 32'(top_data), 32'h00AA);
    cyc("sim_pop", 0, 0, 1, 16'h0);
    check("sim_pop_top", 32'(top_data), 32'h0001);
    cyc("clr", 1, 0, 0, 16'h0);
    cyc("empty_both", 0, 1, 1, 16'h0077);
    check("empty_both_unf", 32'(underflow), 32'd0);

    cyc("clr", 1, 0, 0, 16'h0);
    for (int i = 0; i <= DEPTH; i++) cyc("cm_fill", 0, 1, 0, 16'(16'h0200 + i));
    for (int i = 0; i < DEPTH - 5; i++) cyc("cm_pop", 0, 0, 1, 16'h0);
    check("cm_cnt5", 32'(count), 32'd5);
    check("cm_ovf", 32'(overflow), 32'd1);
    cyc("cm_clear_push", 1, 1, 0, 16'h1234);
    check("cm_clr_cnt", 32'(count), 32'd0);
    check("cm_clr_ovf", 32'(overflow), 32'd0);

    cyc("ar_push", 0, 1, 0, 16'h0A0A);
    cyc("ar_push", 0, 1, 0, 16'h0B0B);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("after_rst");

    for (int i = 0; i < 800; i++) begin
      cyc("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 45), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/backtrack_stack.md
Name: backtrack_stack

Overview:
- LIFO store for the backtracking datapath. Sits directly downstream of the main controller: consumes its push, poping and load_init strobes.
- Holds one candidate/state word per search level.
- Exposes the current top-of-stack to the result-calculation logic.
- Produces the empty indication that feeds the controller's done input.

Parameters:
WIDTH, 16, bits per stored entry
DEPTH, 16, number of entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous flush (driven by load_init); empties stack
push  input  1  write push_data as new top this cycle
push_data  input  WIDTH  entry to store
pop  input  1  remove top entry this cycle (driven by poping)
top_data  output  WIDTH  registered copy of current top entry
top_valid  output  1  top_data holds a live entry
empty  output  1  count == 0; feeds controller done
full  output  1  count == DEPTH
count  output  CNT_W  number of live entries
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst=1): count=0, top_data=0, top_valid=0, empty=1, full=0, overflow=0, underflow=0. Storage array contents are don't-care and need no reset.
- All updates on rising clk edge. Priority: clear > push/pop.
- clear=1: count=0, top_valid=0, top_data=0, overflow=0, underflow=0. Any push/pop in the same cycle is ignored.
- Push only, not full: mem[count]<=push_data; count+1; top_data<=push_data; top_valid<=1. New top is visible the cycle after the edge (1-cycle latency).
- Push only, full: no write; count, top_data unchanged; overflow<=1.
- Pop only, count>=2: count-1; top_data<=mem[count-2]; top_valid stays 1.
- Pop only, count==1: count=0; top_valid<=0; top_data<=0.
- Pop only, empty: no change; underflow<=1.
- Push and pop together, non-empty: replace top. mem[count-1]<=push_data; top_data<=push_data; count unchanged. Legal even when full.
- Push and pop together, empty: treated as push only; underflow not set.
- Status outputs are combinational from the count register and track it each cycle: empty=(count==0), full=(count==DEPTH).
- overflow/underflow stay set until clear or rst.
- Internal FSM (encodes top_valid): S_EMPTY, S_PART, S_FULL.
  - S_EMPTY -> S_PART on push.
  - S_PART -> S_FULL when a push brings count to DEPTH.
  - S_PART -> S_EMPTY when a pop brings count to 0.
  - S_FULL -> S_PART on pop-only.
  - Any state -> S_EMPTY on clear.
- Pointer arithmetic is unsigned in CNT_W bits and never wraps; the guards above prevent it.
- rst asserted mid-operation aborts any in-flight write. Data written before reset is unrecoverable.

Optional Feature:
- Macro: BACKTRACK_STACK_HWM_EN.
- Defined: adds output high_water [CNT_W], the maximum count reached since the last rst/clear.
  - Updates on the same edge as count.
  - Resets to 0 on rst and on clear.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> empty=1, count=0, top_valid=0, overflow=0, underflow=0.
- LIFO order, DEPTH=16: push 0x0011, 0x0022, 0x0033 on consecutive cycles -> count=3, top_data=0x0033. Then pop 3 times -> top_data 0x0022, 0x0011, then top_valid=0 and empty=1.
- Fill and overflow: push 16 entries 0x0100..0x010F -> full=1. 17th push 0xFFFF -> overflow=1, count=16, top_data=0x010F.
- Underflow: pop on empty stack -> underflow=1, count=0. Then push 0x0042 -> top_data=0x0042, underflow still 1.
- Simultaneous: with stack holding 0x0001, 0x0002, assert push=1, pop=1, data 0x00AA -> count=2, top_data=0x00AA. Next pop -> top_data=0x0001.
- Clear and async reset mid-run:
  - With count=5 and overflow set, pulse clear together with push -> count=0, overflow=0, push ignored.
  - Then push twice and assert rst between clock edges -> outputs reach reset values immediately, before the next edge.
